// File: rtl/extram_fifo_bridge_pkg.sv
// Shared register map, bit positions and helpers for the EXTRAM FIFO bridge.
// The register window decodes only bus_a[3:2]; upper address bits alias.
package extram_fifo_bridge_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int unsigned ST_RX_EMPTY     = 0;
  localparam int unsigned ST_RX_FULL      = 1;
  localparam int unsigned ST_TX_EMPTY     = 2;
  localparam int unsigned ST_TX_FULL      = 3;
  localparam int unsigned ST_RX_UNDERFLOW = 4;
  localparam int unsigned ST_TX_OVERFLOW  = 5;

  localparam int unsigned ST_RX_COUNT_LSB = 8;
  localparam int unsigned ST_TX_COUNT_LSB = 16;
  localparam int unsigned COUNT_WIDTH     = 8;

  localparam int unsigned CTRL_RX_IRQ_EN = 0;
  localparam int unsigned CTRL_TX_IRQ_EN = 1;
  localparam int unsigned CTRL_RX_FLUSH  = 2;
  localparam int unsigned CTRL_TX_FLUSH  = 3;

  // Zero every byte lane whose strobe is low.
  function automatic logic [31:0] strobe_mask(input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strb[i] ? data[8*i +: 8] : 8'h00;
    end
    return res;
  endfunction

endpackage

// File: rtl/extram_fifo_bridge_sync_fifo.sv
// First-word-fall-through circular FIFO with wrap-bit pointers.
// Push is ignored when full, pop when empty; flush overrides both.
module sync_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PtrOne    = 1;
  localparam logic [DEPTH_LOG2:0] FullCount = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]    mem_q [Depth];
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic                do_push, do_pop;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign full    = (count == FullCount);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= din;
  end

endmodule

// File: rtl/extram_fifo_bridge.sv
// EXTRAM register-window responder bridging CPU firmware and a host streaming
// agent through a TX and an RX word FIFO, with status/control and a level irq.
module extram_fifo_bridge
  import extram_fifo_bridge_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned WIDTH      = 32
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [15:0] bus_a,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  input  logic        bus_cs,
  input  logic        bus_oe,
  input  logic [3:0]  bus_wstrb,
  output logic [31:0] hst_tx_data,
  output logic        hst_tx_valid,
  input  logic        hst_tx_ready,
  input  logic [31:0] hst_rx_data,
  input  logic        hst_rx_valid,
  output logic        hst_rx_ready,
  output logic        irq
);

  logic [1:0]  reg_idx;
  logic        rd_acc, wr_acc;
  logic [31:0] wr_data;
  logic        unused_bus_a;

  logic        tx_push, tx_pop, tx_flush, tx_empty, tx_full;
  logic        rx_push, rx_pop, rx_flush, rx_empty, rx_full;
  logic [DEPTH_LOG2:0] tx_count, rx_count;
  logic [WIDTH-1:0]    tx_dout, rx_dout;

  logic rx_uf_q, rx_uf_d, tx_of_q, tx_of_d;
  logic rx_irq_en_q, rx_irq_en_d, tx_irq_en_q, tx_irq_en_d;
  logic irq_q, irq_d;

  logic data_rd, data_wr, status_wr, ctrl_wr;
  logic [31:0] status;

  assign reg_idx      = bus_a[3:2];
  assign unused_bus_a = ^{bus_a[15:4], bus_a[1:0]};
  assign rd_acc       = bus_cs & bus_oe;
  assign wr_acc       = bus_cs & (bus_wstrb != 4'b0000);
  assign wr_data      = strobe_mask(bus_wdata, bus_wstrb);

  assign data_rd   = rd_acc & (reg_idx == REG_DATA);
  assign data_wr   = wr_acc & (reg_idx == REG_DATA);
  assign status_wr = wr_acc & (reg_idx == REG_STATUS);
  assign ctrl_wr   = wr_acc & (reg_idx == REG_CTRL) & bus_wstrb[0];

  // FIFOs gate push on full and pop on empty themselves.
  assign tx_push  = data_wr;
  assign tx_pop   = hst_tx_valid & hst_tx_ready;
  assign tx_flush = ctrl_wr & wr_data[CTRL_TX_FLUSH];
  assign rx_push  = hst_rx_valid;
  assign rx_pop   = data_rd;
  assign rx_flush = ctrl_wr & wr_data[CTRL_RX_FLUSH];

  sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (WIDTH)
  ) u_tx_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (tx_push),
    .pop   (tx_pop),
    .flush (tx_flush),
    .din   (wr_data),
    .dout  (tx_dout),
    .empty (tx_empty),
    .full  (tx_full),
    .count (tx_count)
  );

  sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (WIDTH)
  ) u_rx_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (rx_push),
    .pop   (rx_pop),
    .flush (rx_flush),
    .din   (hst_rx_data),
    .dout  (rx_dout),
    .empty (rx_empty),
    .full  (rx_full),
    .count (rx_count)
  );

  assign hst_tx_data  = tx_dout;
  assign hst_tx_valid = ~tx_empty;
  assign hst_rx_ready = ~rx_full;
  assign irq          = irq_q;

  always_comb begin
    status                                    = '0;
    status[ST_RX_EMPTY]                       = rx_empty;
    status[ST_RX_FULL]                        = rx_full;
    status[ST_TX_EMPTY]                       = tx_empty;
    status[ST_TX_FULL]                        = tx_full;
    status[ST_RX_UNDERFLOW]                   = rx_uf_q;
    status[ST_TX_OVERFLOW]                    = tx_of_q;
    status[ST_RX_COUNT_LSB +: COUNT_WIDTH]    = COUNT_WIDTH'(rx_count);
    status[ST_TX_COUNT_LSB +: COUNT_WIDTH]    = COUNT_WIDTH'(tx_count);
  end

  always_comb begin
    bus_rdata = '0;
    if (rd_acc) begin
      case (reg_idx)
        REG_DATA:   bus_rdata = rx_empty ? '0 : rx_dout;
        REG_STATUS: bus_rdata = status;
        REG_CTRL:   bus_rdata = {30'b0, tx_irq_en_q, rx_irq_en_q};
        default:    bus_rdata = '0;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as its clear wins.
  always_comb begin
    rx_uf_d     = rx_uf_q;
    tx_of_d     = tx_of_q;
    rx_irq_en_d = rx_irq_en_q;
    tx_irq_en_d = tx_irq_en_q;
    if (status_wr && wr_data[ST_RX_UNDERFLOW]) rx_uf_d = 1'b0;
    if (status_wr && wr_data[ST_TX_OVERFLOW])  tx_of_d = 1'b0;
    if (data_rd && rx_empty) rx_uf_d = 1'b1;
    if (data_wr && tx_full)  tx_of_d = 1'b1;
    if (ctrl_wr) begin
      rx_irq_en_d = wr_data[CTRL_RX_IRQ_EN];
      tx_irq_en_d = wr_data[CTRL_TX_IRQ_EN];
    end
    irq_d = (rx_irq_en_q & ~rx_empty) | (tx_irq_en_q & tx_empty);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_uf_q     <= 1'b0;
      tx_of_q     <= 1'b0;
      rx_irq_en_q <= 1'b0;
      tx_irq_en_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      rx_uf_q     <= rx_uf_d;
      tx_of_q     <= tx_of_d;
      rx_irq_en_q <= rx_irq_en_d;
      tx_irq_en_q <= tx_irq_en_d;
      irq_q       <= irq_d;
    end
  end

endmodule

// File: tb/tb_extram_fifo_bridge.sv
// Bench for extram_fifo_bridge: directed scenarios plus random traffic, all
// checked against a queue-based model of the register window and host side.
module tb_extram_fifo_bridge;

  localparam int unsigned Depth = 16;

  logic        clk = 1'b0;
  logic        nrst;
  logic [15:0] bus_a;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_cs;
  logic        bus_oe;
  logic [3:0]  bus_wstrb;
  logic [31:0] hst_tx_data;
  logic        hst_tx_valid;
  logic        hst_tx_ready;
  logic [31:0] hst_rx_data;
  logic        hst_rx_valid;
  logic        hst_rx_ready;
  logic        irq;

  extram_fifo_bridge #(
    .DEPTH_LOG2 (4),
    .WIDTH      (32)
  ) dut (
    .clk          (clk),
    .nrst         (nrst),
    .bus_a        (bus_a),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_cs       (bus_cs),
    .bus_oe       (bus_oe),
    .bus_wstrb    (bus_wstrb),
    .hst_tx_data  (hst_tx_data),
    .hst_tx_valid (hst_tx_valid),
    .hst_tx_ready (hst_tx_ready),
    .hst_rx_data  (hst_rx_data),
    .hst_rx_valid (hst_rx_valid),
    .hst_rx_ready (hst_rx_ready),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  int unsigned err_cnt = 0;
  int unsigned chk_cnt = 0;

  // Reference model state
  logic [31:0] tx_q[$];
  logic [31:0] rx_q[$];
  logic        m_uf, m_of, m_rx_en, m_tx_en, m_irq;

  logic [31:0] last_rdata, last_tx_data;
  logic        last_irq;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    int unsigned rn, tn;
    rn = rx_q.size();
    tn = tx_q.size();
    s = 32'h0;
    s[0] = (rn == 0);
    s[1] = (rn == Depth);
    s[2] = (tn == 0);
    s[3] = (tn == Depth);
    s[4] = m_uf;
    s[5] = m_of;
    s[15:8]  = 8'(rn);
    s[23:16] = 8'(tn);
    return s;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [31:0] d, input logic [3:0] s);
    return d & {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  function automatic logic [15:0] mk_addr(input logic [1:0] idx);
    logic [15:0] a;
    a = 16'($urandom);
    a[3:2] = idx;
    return a;
  endfunction

  task automatic bus_rd(input logic [1:0] idx);
    bus_cs = 1'b1; bus_oe = 1'b1; bus_wstrb = 4'b0000;
    bus_a = mk_addr(idx); bus_wdata = $urandom;
  endtask

  task automatic bus_wr(input logic [1:0] idx, input logic [31:0] d, input logic [3:0] s);
    bus_cs = 1'b1; bus_oe = 1'b0; bus_wstrb = s;
    bus_a = mk_addr(idx); bus_wdata = d;
  endtask

  task automatic bus_none();
    bus_cs = 1'b0; bus_oe = 1'b0; bus_wstrb = 4'b0000;
    bus_a = 16'($urandom); bus_wdata = $urandom;
  endtask

  // Called at the falling edge with inputs set; checks outputs, advances model one clock.
  task automatic step();
    logic [31:0] exp_rd, m;
    int unsigned tn, rn;
    logic rd, wr, irq_n;
    logic [1:0] idx;
    #1;
    tn = tx_q.size();
    rn = rx_q.size();
    rd = bus_cs & bus_oe;
    wr = bus_cs & (bus_wstrb != 4'b0000);
    idx = bus_a[3:2];
    exp_rd = 32'h0;
    if (rd) begin
      if (idx == 2'd0)      exp_rd = (rn != 0) ? rx_q[0] : 32'h0;
      else if (idx == 2'd1) exp_rd = exp_status();
      else if (idx == 2'd2) exp_rd = {30'h0, m_tx_en, m_rx_en};
    end
    check_eq("bus_rdata", bus_rdata, exp_rd);
    check_eq("hst_tx_valid", {31'h0, hst_tx_valid}, {31'h0, tn != 0});
    if (tn != 0) check_eq("hst_tx_data", hst_tx_data, tx_q[0]);
    check_eq("hst_rx_ready", {31'h0, hst_rx_ready}, {31'h0, rn < Depth});
    check_eq("irq", {31'h0, irq}, {31'h0, m_irq});
    last_rdata = bus_rdata;
    last_tx_data = hst_tx_data;
    last_irq = irq;

    irq_n = (m_rx_en && rn != 0) || (m_tx_en && tn == 0);
    m = lane_mask(bus_wdata, bus_wstrb);
    if (hst_tx_ready && tn != 0) void'(tx_q.pop_front());
    if (wr && idx == 2'd0) begin
      if (tn < Depth) tx_q.push_back(m);
    end
    if (rd && idx == 2'd0 && rn != 0) void'(rx_q.pop_front());
    if (hst_rx_valid && rn < Depth) rx_q.push_back(hst_rx_data);
    if (wr && idx == 2'd1) begin
      if (m[4]) m_uf = 1'b0;
      if (m[5]) m_of = 1'b0;
    end
    if (rd && idx == 2'd0 && rn == 0) m_uf = 1'b1;
    if (wr && idx == 2'd0 && tn == Depth) m_of = 1'b1;
    if (wr && idx == 2'd2 && bus_wstrb[0]) begin
      m_rx_en = m[0];
      m_tx_en = m[1];
      if (m[2]) rx_q.delete();
      if (m[3]) tx_q.delete();
    end
    m_irq = irq_n;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    tx_q.delete();
    rx_q.delete();
    m_uf = 0; m_of = 0; m_rx_en = 0; m_tx_en = 0; m_irq = 0;
  endtask

  // Asynchronous reset applied between clock edges.
  task automatic do_reset();
    bus_none();
    #2 nrst = 1'b0;
    #1;
    check_eq("rst_tx_valid", {31'h0, hst_tx_valid}, 32'h0);
    check_eq("rst_rx_ready", {31'h0, hst_rx_ready}, 32'h1);
    check_eq("rst_irq", {31'h0, irq}, 32'h0);
    check_eq("rst_rdata", bus_rdata, 32'h0);
    model_reset();
    @(negedge clk);
    nrst = 1'b1;
  endtask

  initial begin
    int op;
    nrst = 1'b0;
    hst_tx_ready = 1'b0; hst_rx_valid = 1'b0; hst_rx_data = 32'h0;
    bus_none();
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // Reset status
    bus_rd(2'd1); step();
    check_eq("reset_status", last_rdata, 32'h0000_0005);

    // TX ordering
    bus_wr(2'd0, 32'hDEAD_BEEF, 4'hF); step();
    bus_wr(2'd0, 32'h1234_5678, 4'hF); step();
    bus_rd(2'd1); step();
    check_eq("tx_count2", {24'h0, last_rdata[23:16]}, 32'd2);
    check_eq("tx_head", last_tx_data, 32'hDEAD_BEEF);
    bus_none(); hst_tx_ready = 1'b1;
    step(); check_eq("tx_out0", last_tx_data, 32'hDEAD_BEEF);
    step(); check_eq("tx_out1", last_tx_data, 32'h1234_5678);
    hst_tx_ready = 1'b0;
    bus_rd(2'd1); step();
    check_eq("tx_empty_after", {31'h0, last_rdata[2]}, 32'h1);

    // RX fill to full, 17th word held off until the first pop
    bus_none(); hst_rx_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      hst_rx_data = 32'h100 + k; step();
    end
    hst_rx_data = 32'h1FF;
    bus_rd(2'd1); step();
    check_eq("rx_full_status", last_rdata, 32'h0000_1006);
    for (int k = 0; k < 16; k++) begin
      if (k >= 2) hst_rx_valid = 1'b0;
      bus_rd(2'd0); step();
      check_eq("rx_order", last_rdata, 32'h100 + k);
    end
    bus_rd(2'd0); step();
    check_eq("rx_17th", last_rdata, 32'h1FF);

    // Underflow, flag clear, overflow
    bus_rd(2'd0); step();
    check_eq("rx_uf_data", last_rdata, 32'h0);
    bus_rd(2'd1); step();
    check_eq("rx_uf_flag", {31'h0, last_rdata[4]}, 32'h1);
    bus_wr(2'd1, 32'h10, 4'hF); step();
    bus_rd(2'd1); step();
    check_eq("rx_uf_clr", {31'h0, last_rdata[4]}, 32'h0);
    for (int k = 0; k < 17; k++) begin
      bus_wr(2'd0, 32'h200 + k, 4'hF); step();
    end
    bus_rd(2'd1); step();
    check_eq("tx_of_flag", {31'h0, last_rdata[5]}, 32'h1);
    check_eq("tx_of_count", {24'h0, last_rdata[23:16]}, 32'd16);
    bus_none(); hst_tx_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step(); check_eq("tx_drain", last_tx_data, 32'h200 + k);
    end
    step();
    hst_tx_ready = 1'b0;

    // RX interrupt latency
    bus_wr(2'd1, 32'h30, 4'hF); step();
    bus_wr(2'd2, 32'h1, 4'h1); step();
    bus_none(); step();
    check_eq("irq_idle", {31'h0, last_irq}, 32'h0);
    hst_rx_valid = 1'b1; hst_rx_data = 32'h55; step();
    hst_rx_valid = 1'b0;
    step(); check_eq("irq_lag", {31'h0, last_irq}, 32'h0);
    step(); check_eq("irq_rise", {31'h0, last_irq}, 32'h1);
    bus_rd(2'd0); step();
    bus_none();
    step(); check_eq("irq_hold", {31'h0, last_irq}, 32'h1);
    step(); check_eq("irq_fall", {31'h0, last_irq}, 32'h0);

    // Simultaneous flush of both FIFOs with a host push
    for (int k = 0; k < 5; k++) begin
      bus_wr(2'd0, 32'h300 + k, 4'hF); step();
    end
    bus_none(); hst_rx_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      hst_rx_data = 32'h400 + k; step();
    end
    hst_rx_data = 32'h4FF;
    bus_wr(2'd2, 32'hC, 4'h1); step();
    hst_rx_valid = 1'b0;
    bus_rd(2'd1); step();
    check_eq("flush_status", last_rdata, 32'h0000_0005);

    // Single-lane DATA write
    bus_wr(2'd0, 32'hAABB_CCDD, 4'b0001); step();
    bus_none(); step();
    check_eq("byte_write", last_tx_data, 32'h0000_00DD);
    hst_tx_ready = 1'b1; step(); step();

    // Random traffic with a mid-run asynchronous reset
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      hst_tx_ready = (i % 400 < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
      hst_rx_valid = $urandom_range(0, 1);
      hst_rx_data  = $urandom;
      op = $urandom_range(0, 19);
      if (op < 5)       bus_rd(2'd0);
      else if (op < 7)  bus_rd(2'd1);
      else if (op == 7) bus_rd(2'd2);
      else if (op == 8) bus_rd(2'd3);
      else if (op < 14) bus_wr(2'd0, $urandom, 4'($urandom_range(1, 15)));
      else if (op == 14) bus_wr(2'd1, $urandom, 4'($urandom_range(1, 15)));
      else if (op == 15) begin
        logic [31:0] d;
        d = $urandom;
        if ($urandom_range(0, 7) != 0) d[3:2] = 2'b00;
        bus_wr(2'd2, d, 4'($urandom_range(1, 15)));
      end else if (op == 16) bus_wr(2'd3, $urandom, 4'($urandom_range(1, 15)));
      else begin
        bus_none();
        if (op == 17) bus_oe = $urandom_range(0, 1);
        if (op == 18) begin bus_cs = 1'b0; bus_wstrb = 4'($urandom); end
        if (op == 19) bus_cs = 1'b1;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/extram_fifo_bridge.md
Name: extram_fifo_bridge

Overview:
- Responder on the CPU wrapper's EXTRAM register window (cs/oe/wstrb/addr/data, single-cycle access, no wait states).
- Provides a pair of word FIFOs between the RISC-V firmware and a host-side streaming agent, e.g. the GD-ROM packet engine.
  - TX FIFO: CPU to host.
  - RX FIFO: host to CPU.
- Provides status and control registers, plus a level interrupt intended for the wrapper's ext_irq3.

Parameters:
- DEPTH_LOG2, 4, log2 of entries per FIFO (16); legal range 1..7.
- WIDTH, 32, FIFO word width; fixed at 32 to match the bus.

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- bus_a  in  16  byte address; only [3:2] decoded, [15:4] ignored (aliases)
- bus_wdata  in  32  write data from CPU
- bus_rdata  out  32  read data to CPU, combinational
- bus_cs  in  1  window select, already decoded upstream
- bus_oe  in  1  read strobe; asserted for every CPU load, so it is valid only together with bus_cs
- bus_wstrb  in  4  byte-lane write strobes
- hst_tx_data  out  32  head of TX FIFO
- hst_tx_valid  out  1  TX FIFO not empty
- hst_tx_ready  in  1  host consumes head
- hst_rx_data  in  32  word from host
- hst_rx_valid  in  1  host offers word
- hst_rx_ready  out  1  RX FIFO not full
- irq  out  1  registered level interrupt

Behaviour:
- Reset (nrst low, asynchronous):
  - Both FIFOs empty; CTRL and sticky flags cleared; irq=0.
  - hst_tx_valid=0, hst_rx_ready=1, bus_rdata=0 when not selected.
- Access qualification:
  - Read access: bus_cs & bus_oe.
  - Write access: bus_cs & (bus_wstrb!=0).
  - One access per cycle; all side effects take place at the clock edge ending the access cycle.
- Read data: combinational in the same cycle as the read access (the wrapper samples it then); 0 when not a read access.
- Register map by bus_a[3:2]:
  - 0 DATA
    - Read returns the RX head and pops it.
    - Read when RX is empty returns 0, does not pop, and sets rx_underflow.
    - Write pushes one word to TX; unstrobed bytes are pushed as 0.
    - Write when TX is full drops the word and sets tx_overflow.
  - 1 STATUS (read)
    - bit0 rx_empty, bit1 rx_full, bit2 tx_empty, bit3 tx_full.
    - bit4 rx_underflow, bit5 tx_overflow.
    - [15:8] rx_count, [23:16] tx_count, zero-extended.
    - All other bits 0.
  - 1 STATUS (write): writing 1 to bit4 or bit5 clears that flag.
  - 2 CTRL (read/write)
    - bit0 rx_irq_en, bit1 tx_irq_en.
    - bit2 rx_flush, bit3 tx_flush: write-1 pulses, read back as 0.
    - Byte lane 0 strobe required to update CTRL.
  - 3 reserved: reads 0, writes ignored.
- FIFOs:
  - First-word-fall-through circular buffers.
  - Pointers are DEPTH_LOG2+1 bits with a wrap bit; count = wr_ptr - rd_ptr.
  - full = (count == 2^DEPTH_LOG2).
- Host handshake:
  - Host transfer on valid&ready at the clock edge.
  - hst_rx_ready = !rx_full; no pass-through when full.
  - hst_tx_data is stable while hst_tx_valid=1 and no pop occurs.
- Simultaneous events:
  - Push and pop on the same FIFO in one cycle: both happen, count unchanged.
  - A CPU DATA write on an empty TX FIFO sets hst_tx_valid the next cycle; no same-cycle bypass.
  - A host push and a CPU DATA read of an empty RX FIFO in the same cycle: the read returns 0 and flags underflow; the pushed word remains.
  - A flush in the same cycle as a push or pop on that FIFO: flush wins and the FIFO ends empty. This includes discarding a host word accepted that cycle.
  - A sticky flag set and its clear in the same cycle: set wins.
- irq: registered each cycle as (rx_irq_en & !rx_empty) | (tx_irq_en & tx_empty); one-cycle latency after the state change.
- Reset mid-transfer: everything is discarded immediately; no partial words.

Decomposition:
- Shared package extram_fifo_bridge_pkg:
  - register index constants (REG_DATA=0, REG_STATUS=1, REG_CTRL=2);
  - STATUS and CTRL bit positions;
  - count field offsets.
- One sub-module, sync_fifo (parameters DEPTH_LOG2, WIDTH):
  - ports push, pop, flush, din, dout, empty, full, count;
  - instantiated twice (TX and RX).
- The top level holds the register decode, sticky flags, CTRL and irq.

Test Plan:
- Reset, then read STATUS -> 0x00000005 (rx_empty, tx_empty); hst_rx_ready=1, hst_tx_valid=0, irq=0.
- Write DATA 0xDEADBEEF, 0x12345678 with hst_tx_ready=0 -> STATUS[23:16]=2; hst_tx_data=0xDEADBEEF. Then raise hst_tx_ready for 2 cycles -> words out in order; tx_empty=1.
- Host pushes 16 words, the 17th held -> hst_rx_ready=0 after the 16th; rx_full=1, rx_count=16. Read DATA 16 times -> values in order; the 17th word is accepted after the first pop.
- Read DATA when empty -> 0x00000000 and STATUS bit4=1. Write STATUS 0x10 -> bit4=0. Write 17 words to a full TX -> STATUS bit5=1 and the 17th word is lost.
- CTRL=0x1 with RX empty -> irq=0. Host push -> irq=1 one cycle after rx_empty falls. Read DATA -> irq=0 one cycle after empty.
- Fill TX to 5 and RX to 3, write CTRL=0xC in the same cycle as a host push -> both counts 0 and both empty next cycle. Byte write to DATA with wstrb=0001, bus_wdata=0xAABBCCDD -> TX word 0x000000DD.
